// File: rtl/ac_stream_arbiter.sv
// Round-robin arbiter merging the a- and c-streams onto one tagged write port with burst grants.
// Latency: 1 cycle from accepted beat to out_valid; each grant costs one IDLE cycle.
// Backpressure: a single output slot; upstream ready drops while the slot is full and out_rdy is low.

package ising_config;
  localparam int num_bits = 8;
endpackage

module ac_stream_arbiter
  import ising_config::*;
#(
  parameter int burst_len = 4,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [num_bits-1:0]  a_data,
  input  logic                 a_valid,
  output logic                 a_rdy,
  input  logic [num_bits-1:0]  c_data,
  input  logic                 c_valid,
  output logic                 c_rdy,
  output logic [num_bits-1:0]  out_data,
  output logic                 out_sel,
  output logic                 out_valid,
  input  logic                 out_rdy,
  output logic [cnt_width-1:0] a_count,
  output logic [cnt_width-1:0] c_count,
  output logic                 busy
);

  // Beat counter only needs to hold 0..burst_len-1; it returns to 0 on the last beat.
  localparam int bw = (burst_len > 1) ? $clog2(burst_len) : 1;
  localparam logic [bw-1:0] last_beat = bw'(burst_len - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_C = 2'd2
  } state_t;

  state_t        state;
  logic          rr_ptr;     // 0: a preferred on the next contended grant, 1: c preferred
  logic [bw-1:0] beat_cnt;
  logic          slot_free;
  logic          xfer_a;
  logic          xfer_c;

  assign slot_free = !out_valid || out_rdy;
  assign a_rdy     = (state == GRANT_A) && slot_free;
  assign c_rdy     = (state == GRANT_C) && slot_free;
  assign xfer_a    = a_valid && a_rdy;
  assign xfer_c    = c_valid && c_rdy;
  assign busy      = (state != IDLE) || out_valid;

  // Grant FSM: round-robin on contention, burst-limited, releases early when the other side waits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      beat_cnt <= '0;
    end else if (clr) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (a_valid && c_valid) begin
            state  <= rr_ptr ? GRANT_C : GRANT_A;
            rr_ptr <= ~rr_ptr;
          end else if (a_valid) begin
            state <= GRANT_A;
          end else if (c_valid) begin
            state <= GRANT_C;
          end
        end
        GRANT_A: begin
          if (xfer_a) begin
            if (beat_cnt == last_beat) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else if (!a_valid && c_valid) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end
        end
        GRANT_C: begin
          if (xfer_c) begin
            if (beat_cnt == last_beat) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else if (!c_valid && a_valid) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  // Output slot: load on transfer, drain when downstream takes it, otherwise hold stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_sel   <= 1'b0;
      out_valid <= 1'b0;
    end else if (clr) begin
      out_data  <= '0;
      out_sel   <= 1'b0;
      out_valid <= 1'b0;
    end else if (xfer_a) begin
      out_data  <= a_data;
      out_sel   <= 1'b0;
      out_valid <= 1'b1;
    end else if (xfer_c) begin
      out_data  <= c_data;
      out_sel   <= 1'b1;
      out_valid <= 1'b1;
    end else if (out_rdy) begin
      out_valid <= 1'b0;
    end
  end

  // Per-stream accepted-beat counters, saturating at all-ones for software readback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_count <= '0;
      c_count <= '0;
    end else if (clr) begin
      a_count <= '0;
      c_count <= '0;
    end else begin
      if (xfer_a && (a_count != '1)) a_count <= a_count + 1'b1;
      if (xfer_c && (c_count != '1)) c_count <= c_count + 1'b1;
    end
  end

endmodule
